// File: rtl/circular_buffer.sv
// Input-port flit FIFO for a NoC router: circular storage, first-word-fall-through
// head, empty/full status and hysteretic on/off flow control toward the sender.

package params_noc;
  localparam logic [1:0] FLIT_HEAD      = 2'b00;
  localparam logic [1:0] FLIT_BODY      = 2'b01;
  localparam logic [1:0] FLIT_TAIL      = 2'b10;
  localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

  typedef struct packed {
    logic [1:0]  flit_type;
    logic [3:0]  x_Dest;
    logic [3:0]  y_Dest;
    logic [23:0] payload;
  } flit_Data_noVC;
endpackage

module circular_buffer
  import params_noc::*;
#(
  parameter int BUFFER_SIZE = 8,
  parameter int OFF_LEVEL   = BUFFER_SIZE - 2,
  parameter int ON_LEVEL    = BUFFER_SIZE / 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  flit_Data_noVC input_Data,
  input  logic          write_i,
  input  logic          read_i,
  output flit_Data_noVC output_Data,
  output logic          buf_empty,
  output logic          buf_full,
  output logic          buf_On_Off
);

  localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUFFER_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] CNT_OFF   = CNT_W'(OFF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_ON    = CNT_W'(ON_LEVEL);

  flit_Data_noVC    mem [BUFFER_SIZE];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             on_off_reg, on_off_next;
  logic             wr_en, rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign buf_empty  = (count_reg == '0);
  assign buf_full   = (count_reg == CNT_FULL);
  assign buf_On_Off = on_off_reg;

  // A write into a full buffer is only legal when the head leaves in the same cycle.
  assign wr_en = write_i && (!buf_full || read_i);
  assign rd_en = read_i && !buf_empty;

  assign output_Data = buf_empty ? '0 : mem[rd_ptr_reg];

  always_comb begin
    rd_ptr_next = rd_en ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    wr_ptr_next = wr_en ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    count_next  = count_reg;
    if (wr_en && !rd_en)
      count_next = count_reg + 1'b1;
    else if (rd_en && !wr_en)
      count_next = count_reg - 1'b1;
  end

  // Hysteresis looks at next-cycle occupancy so the sender sees OFF one edge earlier.
  always_comb begin
    on_off_next = on_off_reg;
    if (on_off_reg && (count_next >= CNT_OFF))
      on_off_next = 1'b0;
    else if (!on_off_reg && (count_next <= CNT_ON))
      on_off_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      on_off_reg <= 1'b1;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      on_off_reg <= on_off_next;
    end
  end

  // Storage is left out of reset; count gates the head so stale data never leaks.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= input_Data;
  end

endmodule

// File: tb/tb_circular_buffer.sv
// Self-checking bench for circular_buffer: vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.

module tb_circular_buffer;
  import params_noc::*;

  localparam int DEPTH = 8;
  localparam int OFF_L = 6;
  localparam int ON_L  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  flit_Data_noVC input_Data = '0;
  logic          write_i = 1'b0;
  logic          read_i = 1'b0;
  flit_Data_noVC output_Data;
  logic          buf_empty, buf_full, buf_On_Off;

  int checks = 0;
  int errors = 0;

  circular_buffer #(.BUFFER_SIZE(DEPTH), .OFF_LEVEL(OFF_L), .ON_LEVEL(ON_L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .input_Data (input_Data),
    .write_i    (write_i),
    .read_i     (read_i),
    .output_Data(output_Data),
    .buf_empty  (buf_empty),
    .buf_full   (buf_full),
    .buf_On_Off (buf_On_Off)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       w;
    logic       r;
    logic [7:0] tag;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_onoff;
    logic       exp_valid;
    logic [7:0] exp_tag;
  } vec_t;

  function automatic flit_Data_noVC mk(input logic [23:0] tag);
    flit_Data_noVC f;
    f.flit_type = FLIT_HEAD;
    f.x_Dest    = 4'd1;
    f.y_Dest    = 4'd1;
    f.payload   = tag;
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle starting from a negedge; returns at the following negedge.
  task automatic cycle(input logic w, input logic r, input flit_Data_noVC d);
    write_i = w;
    read_i = r;
    input_Data = d;
    @(posedge clk);
    @(negedge clk);
    write_i = 1'b0;
    read_i = 1'b0;
    input_Data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  vec_t vecs[10];
  flit_Data_noVC q[$];
  flit_Data_noVC a, b, c, exp_out;
  logic model_on;

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_empty", 32'(buf_empty), 32'd1);
    chk("reset_full", 32'(buf_full), 32'd0);
    chk("reset_onoff", 32'(buf_On_Off), 32'd1);
    chk("reset_out", output_Data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table: {w, r, tag, empty, full, on_off, head_valid, head_tag}
    vecs[0] = '{1'b1, 1'b0, 8'd10, 1'b0, 1'b0, 1'b1, 1'b1, 8'd10};
    vecs[1] = '{1'b1, 1'b0, 8'd11, 1'b0, 1'b0, 1'b1, 1'b1, 8'd10};
    vecs[2] = '{1'b1, 1'b0, 8'd12, 1'b0, 1'b0, 1'b1, 1'b1, 8'd10};
    vecs[3] = '{1'b0, 1'b1, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'd11};
    vecs[4] = '{1'b1, 1'b1, 8'd13, 1'b0, 1'b0, 1'b1, 1'b1, 8'd12};
    vecs[5] = '{1'b0, 1'b1, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'd13};
    vecs[6] = '{1'b0, 1'b1, 8'd0,  1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[7] = '{1'b0, 1'b1, 8'd0,  1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[8] = '{1'b1, 1'b1, 8'd14, 1'b0, 1'b0, 1'b1, 1'b1, 8'd14};
    vecs[9] = '{1'b0, 1'b0, 8'd99, 1'b0, 1'b0, 1'b1, 1'b1, 8'd14};
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].w, vecs[i].r, mk(24'(vecs[i].tag)));
      exp_out = vecs[i].exp_valid ? mk(24'(vecs[i].exp_tag)) : '0;
      chk($sformatf("vec%0d_empty", i), 32'(buf_empty), 32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d_full", i), 32'(buf_full), 32'(vecs[i].exp_full));
      chk($sformatf("vec%0d_onoff", i), 32'(buf_On_Off), 32'(vecs[i].exp_onoff));
      chk($sformatf("vec%0d_out", i), output_Data, exp_out);
      $display("vec %0d: w=%0b r=%0b out=%h empty=%0b", i, vecs[i].w, vecs[i].r, output_Data, buf_empty);
    end

    // Asynchronous reset mid-stream after three writes.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, mk(24'(20 + i)));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_empty", 32'(buf_empty), 32'd1);
    chk("async_rst_full", 32'(buf_full), 32'd0);
    chk("async_rst_onoff", 32'(buf_On_Off), 32'd1);
    chk("async_rst_out", output_Data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cycle(1'b0, 1'b1, '0);
    chk("rst_read_empty", 32'(buf_empty), 32'd1);
    $display("async reset: empty=%0b out=%h", buf_empty, output_Data);

    // Single write then zero-latency read.
    cycle(1'b1, 1'b0, mk(24'h0));
    chk("single_out", output_Data, mk(24'h0));
    chk("single_nonempty", 32'(buf_empty), 32'd0);
    read_i = 1'b1;
    #1 chk("single_fwft", output_Data, mk(24'h0));
    @(posedge clk);
    @(negedge clk);
    read_i = 1'b0;
    chk("single_drained", 32'(buf_empty), 32'd1);
    $display("single write/read done: empty=%0b", buf_empty);

    // Fill to full, drop the overflow write, drain in order; check flow control.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, mk(24'(i)));
      chk($sformatf("fill%0d_onoff", i), 32'(buf_On_Off), (i + 1 >= OFF_L) ? 32'd0 : 32'd1);
    end
    chk("fill_full", 32'(buf_full), 32'd1);
    cycle(1'b1, 1'b0, mk(24'd8));
    chk("overflow_full", 32'(buf_full), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d_out", i), output_Data, mk(24'(i)));
      cycle(1'b0, 1'b1, '0);
      // count after this read is DEPTH-1-i; ON returns only at <= ON_L
      chk($sformatf("drain%0d_onoff", i), 32'(buf_On_Off), (DEPTH - 1 - i <= ON_L) ? 32'd1 : 32'd0);
    end
    chk("drain_empty", 32'(buf_empty), 32'd1);
    chk("drain_out_zero", output_Data, 32'd0);
    $display("fill/drain done: empty=%0b", buf_empty);

    // Simultaneous read+write when non-empty.
    a = mk(24'hA); b = mk(24'hB); c = mk(24'hC);
    cycle(1'b1, 1'b0, a);
    cycle(1'b1, 1'b0, b);
    write_i = 1'b1; read_i = 1'b1; input_Data = c;
    #1 chk("rw_before", output_Data, a);
    @(posedge clk);
    @(negedge clk);
    write_i = 1'b0; read_i = 1'b0;
    chk("rw_after", output_Data, b);
    cycle(1'b0, 1'b1, '0);
    chk("rw_second", output_Data, c);
    cycle(1'b0, 1'b1, '0);
    chk("rw_count2_empty", 32'(buf_empty), 32'd1);

    // Simultaneous read+write when full.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, mk(24'(40 + i)));
    cycle(1'b1, 1'b1, mk(24'd48));
    chk("rw_full_full", 32'(buf_full), 32'd1);
    chk("rw_full_out", output_Data, mk(24'd41));

    // Simultaneous read+write when empty: write only.
    do_reset();
    cycle(1'b1, 1'b1, mk(24'h55));
    chk("rw_empty_nonempty", 32'(buf_empty), 32'd0);
    chk("rw_empty_out", output_Data, mk(24'h55));
    $display("simultaneous read/write cases done");

    // Randomized traffic against a queue model.
    do_reset();
    q.delete();
    model_on = 1'b1;
    for (int n = 0; n < 80; n++) begin
      logic w, r, rd_ok, wr_ok;
      flit_Data_noVC d;
      w = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 9) < 5);
      d = flit_Data_noVC'($urandom);
      rd_ok = r && (q.size() > 0);
      wr_ok = w && (q.size() < DEPTH || r);
      cycle(w, r, d);
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(d);
      if (model_on && q.size() >= OFF_L) model_on = 1'b0;
      else if (!model_on && q.size() <= ON_L) model_on = 1'b1;
      exp_out = (q.size() > 0) ? q[0] : '0;
      chk($sformatf("rand%0d_out", n), output_Data, exp_out);
      chk($sformatf("rand%0d_empty", n), 32'(buf_empty), 32'(q.size() == 0));
      chk($sformatf("rand%0d_full", n), 32'(buf_full), 32'(q.size() == DEPTH));
      chk($sformatf("rand%0d_onoff", n), 32'(buf_On_Off), 32'(model_on));
      $display("rand %0d: w=%0b r=%0b size=%0d out=%h", n, w, r, q.size(), output_Data);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog timeout");
  end

endmodule
